// File: rtl/up_dn_counter_param.sv
// rtl/up_dn_counter_param.sv - parametrised bounded up/down counter with saturate/wrap modes
//
// Purpose: bounded event, timer or credit counter. It has a runtime step, runtime
// inclusive bounds, saturate or wrap behaviour, and a one-cycle wrap pulse.
// Optional feature macro: UP_DN_CNT_STICKY_EN. When it is defined, the block adds
// sticky overflow and underflow flags and a clear input for them.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   IN         load value, clamped into [lo_lim, hi_lim]
//   load       load IN on the next edge (highest priority)
//   up/down    count by step (down wins when both are set)
//   step       increment/decrement magnitude
//   lo_lim     inclusive lower bound
//   hi_lim     inclusive upper bound
//   wrap_mode  0 = saturate at bounds, 1 = jump to the opposite bound
//   Counter    registered count
//   high/low   Counter equals hi_lim / lo_lim
//   wrap_p     registered pulse: the last update wrapped
//   cfg_err    lo_lim > hi_lim; the counter freezes while this is set
//   sticky_clr, ovf_sticky, unf_sticky  (UP_DN_CNT_STICKY_EN only)

module up_dn_counter_param #(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IN,
  input  logic             load,
  input  logic             up,
  input  logic             down,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lo_lim,
  input  logic [WIDTH-1:0] hi_lim,
  input  logic             wrap_mode,
`ifdef UP_DN_CNT_STICKY_EN
  input  logic             sticky_clr,
  output logic             ovf_sticky,
  output logic             unf_sticky,
`endif
  output logic [WIDTH-1:0] Counter,
  output logic             high,
  output logic             low,
  output logic             wrap_p,
  output logic             cfg_err
);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             wrap_p_q, wrap_p_d;

  // One extra bit so that sums near the top of the range never alias.
  logic [WIDTH:0] cnt_x, step_x, lo_x, hi_x, sum_x, lo_plus_x;
  logic           in_range;
  logic           step_nz;
  logic           lims_equal;

  assign cnt_x      = {1'b0, counter_q};
  assign step_x     = {1'b0, step};
  assign lo_x       = {1'b0, lo_lim};
  assign hi_x       = {1'b0, hi_lim};
  assign sum_x      = cnt_x + step_x;
  assign lo_plus_x  = lo_x + step_x;
  assign in_range   = (counter_q >= lo_lim) && (counter_q <= hi_lim);
  assign step_nz    = (step != '0);
  assign lims_equal = (lo_lim == hi_lim);

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                             input logic [WIDTH-1:0] lo,
                                             input logic [WIDTH-1:0] hi);
    if (v < lo)      clamp = lo;
    else if (v > hi) clamp = hi;
    else             clamp = v;
  endfunction

  always_comb begin
    counter_d = counter_q;
    wrap_p_d  = 1'b0;
    if (!cfg_err) begin
      if (load) begin
        counter_d = clamp(IN, lo_lim, hi_lim);
      end else if (up || down) begin
        if (!in_range) begin
          // Bounds moved under the counter: pull it back in first, with no step applied.
          counter_d = clamp(counter_q, lo_lim, hi_lim);
        end else if (step_nz) begin
          if (down) begin
            // cnt - step < lo  is evaluated as  cnt < lo + step  so nothing underflows.
            if (cnt_x < lo_plus_x) begin
              counter_d = wrap_mode ? hi_lim : lo_lim;
              // With equal bounds the counter is pinned, so no wrap is reported.
              wrap_p_d  = wrap_mode && !lims_equal;
            end else begin
              counter_d = counter_q - step;
            end
          end else begin
            if (sum_x > hi_x) begin
              counter_d = wrap_mode ? lo_lim : hi_lim;
              wrap_p_d  = wrap_mode && !lims_equal;
            end else begin
              counter_d = sum_x[WIDTH-1:0];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_q <= RST_VAL;
      wrap_p_q  <= 1'b0;
    end else begin
      counter_q <= counter_d;
      wrap_p_q  <= wrap_p_d;
    end
  end

`ifdef UP_DN_CNT_STICKY_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic step_active, ovf_hit, unf_hit;

  // Only an in-range counting step can hit a bound. Load, clamp and hold never set the flags.
  assign step_active = !cfg_err && !load && in_range && step_nz;
  assign ovf_hit     = step_active && up && !down && (sum_x >= hi_x);
  assign unf_hit     = step_active && down && (cnt_x <= lo_plus_x);

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (sticky_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    // A set in the same cycle takes priority over a clear.
    if (ovf_hit) ovf_d = 1'b1;
    if (unf_hit) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;
`endif

  assign Counter = counter_q;
  assign wrap_p  = wrap_p_q;
  assign high    = (counter_q == hi_lim);
  assign low     = (counter_q == lo_lim);
  assign cfg_err = (lo_lim > hi_lim);

endmodule

// File: tb/tb_up_dn_counter_param.sv
// tb/tb_up_dn_counter_param.sv - self-checking bench for up_dn_counter_param

module tb_up_dn_counter_param;

  logic       clk;
  logic       rst;
  logic [4:0] IN;
  logic       load, up, down, wrap_mode;
  logic [4:0] step, lo_lim, hi_lim;
  logic       sticky_clr;
  logic [4:0] Counter;
  logic       high, low, wrap_p, cfg_err;
`ifdef UP_DN_CNT_STICKY_EN
  logic       ovf_sticky, unf_sticky;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int m_cnt;
  bit m_wrap;
  bit m_ovf, m_unf;

  up_dn_counter_param #(.WIDTH(5), .RST_VAL(5'd0)) dut (
    .clk(clk), .rst(rst), .IN(IN), .load(load), .up(up), .down(down),
    .step(step), .lo_lim(lo_lim), .hi_lim(hi_lim), .wrap_mode(wrap_mode),
`ifdef UP_DN_CNT_STICKY_EN
    .sticky_clr(sticky_clr), .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky),
`endif
    .Counter(Counter), .high(high), .low(low), .wrap_p(wrap_p), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // The model works on plain integers. The next value follows the priority rules:
  // freeze on bad bounds, then load, then clamp, then step, then saturate or wrap.
  task automatic model_edge();
    int lo = int'(lo_lim);
    int hi = int'(hi_lim);
    int s  = int'(step);
    int c  = m_cnt;
    int t;
    bit ovf = 0, unf = 0;
    m_wrap = 0;
    if (lo > hi) begin
      // frozen
    end else if (load) begin
      m_cnt = clampi(int'(IN), lo, hi);
    end else if (up || down) begin
      if (c < lo || c > hi) begin
        m_cnt = clampi(c, lo, hi);
      end else if (s != 0) begin
        if (down) begin
          t   = c - s;
          unf = (t <= lo);
          if (t < lo) begin
            m_cnt  = wrap_mode ? hi : lo;
            m_wrap = wrap_mode && (lo != hi);
          end else m_cnt = t;
        end else begin
          t   = c + s;
          ovf = (t >= hi);
          if (t > hi) begin
            m_cnt  = wrap_mode ? lo : hi;
            m_wrap = wrap_mode && (lo != hi);
          end else m_cnt = t;
        end
      end
    end
    m_ovf = ovf ? 1'b1 : (sticky_clr ? 1'b0 : m_ovf);
    m_unf = unf ? 1'b1 : (sticky_clr ? 1'b0 : m_unf);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wrap = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic set_ops(input bit l, input bit u, input bit d);
    load = l; up = u; down = d;
  endtask

  task automatic test_reset();
    rst = 1'b0; IN = '0; set_ops(0, 0, 0); step = 5'd1;
    lo_lim = 5'd0; hi_lim = 5'd31; wrap_mode = 1'b0; sticky_clr = 1'b0;
    model_reset();
    #13;
    n_total++; if (Counter !== 5'd0) $display("FAIL reset_counter got %0d want 0", Counter); else n_pass++;
    n_total++; if (wrap_p !== 1'b0) $display("FAIL reset_wrap_p got %b want 0", wrap_p); else n_pass++;
    n_total++; if (low !== 1'b1 || high !== 1'b0) $display("FAIL reset_flags got low=%b high=%b want 1 0", low, high); else n_pass++;
    n_total++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err got %b want 0", cfg_err); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_priority();
    IN = 5'd3; set_ops(1, 0, 0); tick();
    n_total++; if (Counter !== 5'd3) $display("FAIL prio_load got %0d want 3", Counter); else n_pass++;
    set_ops(0, 1, 0); tick();
    n_total++; if (Counter !== 5'd4) $display("FAIL prio_up got %0d want 4", Counter); else n_pass++;
    set_ops(0, 1, 1); tick();
    n_total++; if (Counter !== 5'd3) $display("FAIL prio_down_wins got %0d want 3", Counter); else n_pass++;
  endtask

  task automatic test_saturate();
    int seen_wrap = 0;
    set_ops(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++; if (Counter !== 5'(m_cnt)) $display("FAIL sat_down[%0d] got %0d want %0d", i, Counter, m_cnt); else n_pass++;
      if (wrap_p) seen_wrap++;
    end
    n_total++; if (Counter !== 5'd0 || low !== 1'b1) $display("FAIL sat_low got cnt=%0d low=%b want 0 1", Counter, low); else n_pass++;
    set_ops(0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wrap_p) seen_wrap++;
    end
    n_total++; if (Counter !== 5'd31 || high !== 1'b1) $display("FAIL sat_high got cnt=%0d high=%b want 31 1", Counter, high); else n_pass++;
    n_total++; if (seen_wrap != 0) $display("FAIL sat_no_wrap got %0d wrap pulses want 0", seen_wrap); else n_pass++;
  endtask

  task automatic test_wrap();
    lo_lim = 5'd4; hi_lim = 5'd20; step = 5'd5; wrap_mode = 1'b1;
    IN = 5'd18; set_ops(1, 0, 0); tick();
    set_ops(0, 1, 0); tick();
    n_total++; if (Counter !== 5'd4 || wrap_p !== 1'b1) $display("FAIL wrap_up got cnt=%0d wrap_p=%b want 4 1", Counter, wrap_p); else n_pass++;
    set_ops(0, 0, 0); tick();
    n_total++; if (Counter !== 5'd4 || wrap_p !== 1'b0) $display("FAIL wrap_pulse_len got cnt=%0d wrap_p=%b want 4 0", Counter, wrap_p); else n_pass++;
    set_ops(0, 0, 1); tick();
    n_total++; if (Counter !== 5'd20 || wrap_p !== 1'b1) $display("FAIL wrap_down got cnt=%0d wrap_p=%b want 20 1", Counter, wrap_p); else n_pass++;
    IN = 5'd15; set_ops(1, 0, 0); tick();
    set_ops(0, 1, 0); tick();
    n_total++; if (Counter !== 5'd20 || wrap_p !== 1'b0) $display("FAIL wrap_exact_hi got cnt=%0d wrap_p=%b want 20 0", Counter, wrap_p); else n_pass++;
  endtask

  task automatic test_clamp();
    lo_lim = 5'd10; hi_lim = 5'd20; wrap_mode = 1'b0;
    IN = 5'd25; set_ops(1, 0, 0); tick();
    n_total++; if (Counter !== 5'd20 || high !== 1'b1) $display("FAIL clamp_hi got cnt=%0d high=%b want 20 1", Counter, high); else n_pass++;
    IN = 5'd2; tick();
    n_total++; if (Counter !== 5'd10) $display("FAIL clamp_lo got %0d want 10", Counter); else n_pass++;
    lo_lim = 5'd12; set_ops(0, 1, 0); tick();
    n_total++; if (Counter !== 5'd12 || wrap_p !== 1'b0) $display("FAIL clamp_only got cnt=%0d wrap_p=%b want 12 0", Counter, wrap_p); else n_pass++;
  endtask

  task automatic test_cfg_err();
    lo_lim = 5'd9; hi_lim = 5'd8; #1;
    n_total++; if (cfg_err !== 1'b1) $display("FAIL cfg_err_flag got %b want 1", cfg_err); else n_pass++;
    IN = 5'd3;
    for (int i = 0; i < 3; i++) begin
      set_ops(i == 0, i == 1, i == 2); tick();
      n_total++; if (Counter !== 5'd12 || wrap_p !== 1'b0) $display("FAIL cfg_err_hold[%0d] got cnt=%0d wrap_p=%b want 12 0", i, Counter, wrap_p); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    lo_lim = 5'd8; hi_lim = 5'd20; step = 5'd15; wrap_mode = 1'b1;
    IN = 5'd10; set_ops(1, 0, 0); tick();
    set_ops(0, 1, 0); tick();
    n_total++; if (Counter !== 5'd8 || wrap_p !== 1'b1) $display("FAIL mid_pre_wrap got cnt=%0d wrap_p=%b want 8 1", Counter, wrap_p); else n_pass++;
    #3; rst = 1'b0; #1;
    model_reset();
    n_total++; if (Counter !== 5'd0 || wrap_p !== 1'b0) $display("FAIL mid_reset_async got cnt=%0d wrap_p=%b want 0 0", Counter, wrap_p); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (Counter !== 5'd0) $display("FAIL mid_reset_held got %0d want 0", Counter); else n_pass++;
    #3; rst = 1'b1;
    tick();
    n_total++; if (Counter !== 5'd8 || wrap_p !== 1'b0) $display("FAIL mid_post_clamp got cnt=%0d wrap_p=%b want 8 0", Counter, wrap_p); else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    lo_lim = 5'd0; hi_lim = 5'd31; wrap_mode = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ((i % 16) == 0) begin
        lo_lim = 5'($urandom_range(0, 31));
        hi_lim = 5'($urandom_range(0, 31));
        if (lo_lim > hi_lim && $urandom_range(0, 7) != 0) begin
          logic [4:0] tmp;
          tmp = lo_lim; lo_lim = hi_lim; hi_lim = tmp;
        end
        wrap_mode = 1'($urandom_range(0, 1));
      end
      IN         = 5'($urandom_range(0, 31));
      step       = 5'($urandom_range(0, 9));
      load       = ($urandom_range(0, 9) == 0);
      up         = 1'($urandom_range(0, 1));
      down       = ($urandom_range(0, 2) == 0);
      sticky_clr = ($urandom_range(0, 5) == 0);
      tick();
      n_total++;
      if (Counter !== 5'(m_cnt) || wrap_p !== m_wrap ||
          high !== (m_cnt == int'(hi_lim)) || low !== (m_cnt == int'(lo_lim)) ||
          cfg_err !== (lo_lim > hi_lim)) begin
        if (errs < 10)
          $display("FAIL rand[%0d] got cnt=%0d wrap_p=%b high=%b low=%b cfg_err=%b want cnt=%0d wrap_p=%b (lo=%0d hi=%0d)",
                   i, Counter, wrap_p, high, low, cfg_err, m_cnt, m_wrap, lo_lim, hi_lim);
        errs++;
      end else n_pass++;
`ifdef UP_DN_CNT_STICKY_EN
      n_total++;
      if (ovf_sticky !== m_ovf || unf_sticky !== m_unf)
        $display("FAIL rand_sticky[%0d] got ovf=%b unf=%b want %b %b", i, ovf_sticky, unf_sticky, m_ovf, m_unf);
      else n_pass++;
`endif
    end
    sticky_clr = 1'b0;
  endtask

`ifdef UP_DN_CNT_STICKY_EN
  task automatic test_sticky();
    rst = 1'b0; #2; rst = 1'b1; model_reset();
    lo_lim = 5'd0; hi_lim = 5'd31; step = 5'd4; wrap_mode = 1'b0; sticky_clr = 1'b0;
    IN = 5'd26; set_ops(1, 0, 0); tick();
    n_total++; if (ovf_sticky !== 1'b0) $display("FAIL sticky_init got %b want 0", ovf_sticky); else n_pass++;
    set_ops(0, 1, 0); tick(); tick();
    n_total++; if (Counter !== 5'd31 || ovf_sticky !== 1'b1) $display("FAIL sticky_set got cnt=%0d ovf=%b want 31 1", Counter, ovf_sticky); else n_pass++;
    set_ops(0, 0, 0); tick();
    n_total++; if (ovf_sticky !== 1'b1) $display("FAIL sticky_hold got %b want 1", ovf_sticky); else n_pass++;
    sticky_clr = 1'b1; set_ops(0, 1, 0); tick();
    n_total++; if (ovf_sticky !== 1'b1) $display("FAIL sticky_set_wins got %b want 1", ovf_sticky); else n_pass++;
    set_ops(0, 0, 0); tick();
    n_total++; if (ovf_sticky !== 1'b0) $display("FAIL sticky_clear got %b want 0", ovf_sticky); else n_pass++;
    sticky_clr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_priority();
    test_saturate();
    test_wrap();
    test_clamp();
    test_cfg_err();
    test_reset_mid();
    test_random();
`ifdef UP_DN_CNT_STICKY_EN
    test_sticky();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
